matrix_op_xform: RTL and testbench

//  Parametrised single-operand matrix transform engine: COPY, TRANSPOSE or SCALE (saturating

---
 rtl/matrix_op_xform.sv | 180 ++++++++++++++++++
 tb/tb_matrix_op_xform.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_op_xform.sv
// Single-operand matrix transform engine: COPY, TRANSPOSE or saturating SCALE
// of an M x N row-major matrix, with a read pipeline matched to BRAM latency.
module matrix_op_xform #(
    parameter int ELEMENT_WIDTH = 8,
    parameter int ADDR_WIDTH    = 9,
    parameter int DIM_WIDTH     = 4,
    parameter int MAX_DIM       = 5,
    parameter int RD_LATENCY    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [DIM_WIDTH-1:0]     dim_m,
    input  logic [DIM_WIDTH-1:0]     dim_n,
    input  logic [ADDR_WIDTH-1:0]    addr_op1,
    input  logic [ADDR_WIDTH-1:0]    addr_res,
    input  logic [ELEMENT_WIDTH-1:0] scalar,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     mem_rd_en,
    output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
    input  logic [ELEMENT_WIDTH-1:0] mem_rd_data,
    output logic                     mem_wr_en,
    output logic [ADDR_WIDTH-1:0]    mem_wr_addr,
    output logic [ELEMENT_WIDTH-1:0] mem_wr_data
);

    localparam int EW = ELEMENT_WIDTH;
    localparam int AW = ADDR_WIDTH;
    localparam int DW = DIM_WIDTH;
    localparam int PW = 2 * ELEMENT_WIDTH;
    localparam int RL = RD_LATENCY;

    localparam logic [1:0] MODE_TR    = 2'b01;
    localparam logic [1:0] MODE_SCALE = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    localparam logic signed [PW-1:0] SAT_HI = {{(EW+1){1'b0}}, {(EW-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_LO = {{(EW+1){1'b1}}, {(EW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t                  state;
    logic [1:0]              mode_q;
    logic [DW-1:0]           m_q;
    logic [DW-1:0]           n_q;
    logic [DW-1:0]           i_q;
    logic [DW-1:0]           j_q;
    logic [AW-1:0]           res_q;
    logic [AW-1:0]           dst_q;
    logic signed [EW-1:0]    scalar_q;
    logic [RL-1:0]           pipe_v;
    logic [AW-1:0]           pipe_a [RL];
    logic signed [PW-1:0]    prod;
    logic [EW-1:0]           scaled;
    logic                    req_bad;
    logic                    last_elem;
    logic                    row_end;

    assign req_bad = (dim_m == '0) || (dim_n == '0) ||
                     (dim_m > DW'(MAX_DIM)) || (dim_n > DW'(MAX_DIM)) ||
                     (mode == MODE_RSVD);
    assign row_end   = (j_q == n_q - DW'(1));
    assign last_elem = row_end && (i_q == m_q - DW'(1));

    // Saturating signed scale of the returning read word
    always_comb begin
        prod   = PW'($signed(mem_rd_data)) * PW'(scalar_q);
        scaled = prod[EW-1:0];
        if (prod > SAT_HI) begin
            scaled = {1'b0, {(EW-1){1'b1}}};
        end else if (prod < SAT_LO) begin
            scaled = {1'b1, {(EW-1){1'b0}}};
        end
    end

    // Control FSM: capture request, walk source row-major, wait for drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mode_q      <= '0;
            m_q         <= '0;
            n_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            res_q       <= '0;
            dst_q       <= '0;
            scalar_q    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mode_q      <= mode;
                        m_q         <= dim_m;
                        n_q         <= dim_n;
                        res_q       <= addr_res;
                        scalar_q    <= scalar;
                        i_q         <= '0;
                        j_q         <= '0;
                        mem_rd_addr <= addr_op1;
                        dst_q       <= addr_res;
                        if (req_bad) begin
                            state <= FIN;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state     <= ISSUE;
                            busy      <= 1'b1;
                            mem_rd_en <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (last_elem) begin
                        mem_rd_en <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        mem_rd_addr <= mem_rd_addr + AW'(1);
                        if (row_end) begin
                            j_q <= '0;
                            i_q <= i_q + DW'(1);
                        end else begin
                            j_q <= j_q + DW'(1);
                        end
                        if (mode_q == MODE_TR) begin
                            dst_q <= row_end ? res_q + AW'(i_q) + AW'(1)
                                             : dst_q + AW'(m_q);
                        end else begin
                            dst_q <= dst_q + AW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (mem_wr_en && (pipe_v == '0)) begin
                        state <= FIN;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read-latency pipeline carrying valid bit and destination, then write stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v      <= '0;
            for (int k = 0; k < RL; k++) pipe_a[k] <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
        end else begin
            pipe_v[0] <= mem_rd_en;
            pipe_a[0] <= dst_q;
            for (int k = 1; k < RL; k++) begin
                pipe_v[k] <= pipe_v[k-1];
                pipe_a[k] <= pipe_a[k-1];
            end
            mem_wr_en <= pipe_v[RL-1];
            if (pipe_v[RL-1]) begin
                mem_wr_addr <= pipe_a[RL-1];
                mem_wr_data <= (mode_q == MODE_SCALE) ? scaled : mem_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_matrix_op_xform.sv
// Bench for matrix_op_xform: two instances (read latency 1 and 3) against
// behavioural BRAM models and an array-based reference of the transform.
module tb_matrix_op_xform;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start   [2];
    logic [1:0] mode    [2];
    logic [3:0] dm      [2];
    logic [3:0] dn      [2];
    logic [8:0] a1      [2];
    logic [8:0] ar      [2];
    logic [7:0] sc      [2];
    logic       busy    [2];
    logic       done    [2];
    logic       err     [2];
    logic       rd_en   [2];
    logic [8:0] rd_addr [2];
    logic [7:0] rd_data [2];
    logic       wr_en   [2];
    logic [8:0] wr_addr [2];
    logic [7:0] wr_data [2];

    logic [7:0] mem [2][512];

    int   ecnt = 0;
    int   e0 [2];
    int   n_rd [2];
    int   n_wr [2];
    int   first_wr [2];
    int   last_wr [2];
    int   done_c [2];
    int   rd_bad [2];
    logic err_seen [2];
    logic busy_at_done [2];
    logic mon_on [2];
    logic [8:0] src_base [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [7:0] rq [LAT];

        matrix_op_xform #(
            .ELEMENT_WIDTH(8), .ADDR_WIDTH(9), .DIM_WIDTH(4),
            .MAX_DIM(5), .RD_LATENCY(LAT)
        ) dut (
            .clk(clk), .rst(rst), .start(start[g]), .mode(mode[g]),
            .dim_m(dm[g]), .dim_n(dn[g]), .addr_op1(a1[g]),
            .addr_res(ar[g]), .scalar(sc[g]), .busy(busy[g]),
            .done(done[g]), .err(err[g]), .mem_rd_en(rd_en[g]),
            .mem_rd_addr(rd_addr[g]), .mem_rd_data(rd_data[g]),
            .mem_wr_en(wr_en[g]), .mem_wr_addr(wr_addr[g]),
            .mem_wr_data(wr_data[g])
        );

        assign rd_data[g] = rq[LAT-1];

        // BRAM model: LAT-deep read pipeline, synchronous write port
        always @(posedge clk) begin
            rq[0] <= mem[g][rd_addr[g]];
            for (int k = 1; k < LAT; k++) rq[k] <= rq[k-1];
            if (wr_en[g]) mem[g][wr_addr[g]] <= wr_data[g];
        end

        // Mid-cycle monitor: cycle numbers relative to the start edge
        always @(negedge clk) begin
            if (mon_on[g]) begin
                if (rd_en[g]) begin
                    if (rd_addr[g] !== 9'(src_base[g] + 9'(n_rd[g])))
                        rd_bad[g]++;
                    n_rd[g]++;
                end
                if (wr_en[g]) begin
                    if (first_wr[g] == 0) first_wr[g] = ecnt - e0[g] + 1;
                    last_wr[g] = ecnt - e0[g] + 1;
                    n_wr[g]++;
                end
                if (done[g] && done_c[g] == 0) begin
                    done_c[g]       = ecnt - e0[g] + 1;
                    err_seen[g]     = err[g];
                    busy_at_done[g] = busy[g];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] sat8(input int p);
        if (p > 127) return 8'h7f;
        if (p < -128) return 8'h80;
        return p[7:0];
    endfunction

    task automatic chk_idle_outputs(input int u, input string tag);
        chk({tag, "_busy"}, 32'(busy[u]), 0);
        chk({tag, "_done"}, 32'(done[u]), 0);
        chk({tag, "_err"}, 32'(err[u]), 0);
        chk({tag, "_rd_en"}, 32'(rd_en[u]), 0);
        chk({tag, "_wr_en"}, 32'(wr_en[u]), 0);
        chk({tag, "_rd_addr"}, 32'(rd_addr[u]), 0);
        chk({tag, "_wr_addr"}, 32'(wr_addr[u]), 0);
        chk({tag, "_wr_data"}, 32'(wr_data[u]), 0);
    endtask

    // kind: 0 normal, 1 extra start pulse while busy, 2 reset after 3rd read
    task automatic run_op(input int u, input int kind, input logic [1:0] md,
                          input int m, input int n, input logic [8:0] ba,
                          input logic [8:0] br, input logic [7:0] s,
                          input int vals[$]);
        logic [7:0] expm [512];
        logic [7:0] v;
        int lat, mn, mism, src, dst, sv;
        bit bad;
        lat = (u == 0) ? 1 : 3;
        bad = (m == 0 || n == 0 || m > 5 || n > 5 || md == 2'b11);
        mn  = m * n;
        @(negedge clk);
        if (!bad) begin
            for (int k = 0; k < mn; k++) begin
                v = (vals.size() > k) ? 8'(vals[k]) : 8'($urandom);
                mem[u][(int'(ba) + k) % 512] <= v;
            end
        end
        #1;
        for (int k = 0; k < 512; k++) expm[k] = mem[u][k];
        if (!bad) begin
            for (int i = 0; i < m; i++) begin
                for (int j = 0; j < n; j++) begin
                    src = (int'(ba) + i * n + j) % 512;
                    dst = (md == 2'b01) ? (int'(br) + j * m + i) % 512
                                        : (int'(br) + i * n + j) % 512;
                    sv = int'($signed(mem[u][src]));
                    expm[dst] = (md == 2'b10)
                        ? sat8(sv * int'($signed(s))) : mem[u][src];
                end
            end
        end
        n_rd[u] = 0; n_wr[u] = 0; first_wr[u] = 0; last_wr[u] = 0;
        done_c[u] = 0; rd_bad[u] = 0; err_seen[u] = 0; busy_at_done[u] = 0;
        src_base[u] = ba;
        e0[u] = ecnt + 1;
        mon_on[u] = 1'b1;
        mode[u] = md; dm[u] = 4'(m); dn[u] = 4'(n);
        a1[u] = ba; ar[u] = br; sc[u] = s; start[u] = 1'b1;
        @(negedge clk);
        start[u] = 1'b0;
        mode[u] = 2'($urandom); dm[u] = 4'($urandom); dn[u] = 4'($urandom);
        a1[u] = 9'($urandom); ar[u] = 9'($urandom); sc[u] = 8'($urandom);
        if (kind == 2) begin
            repeat (3) @(negedge clk);
            rst = 1'b1;
            #1;
            chk_idle_outputs(u, "midrst");
            @(negedge clk);
            rst = 1'b0;
            mon_on[u] = 1'b0;
            @(negedge clk);
            return;
        end
        for (int t = 0; t < 200 && done_c[u] == 0; t++) begin
            if (kind == 1 && t == 1) begin
                mode[u] = 2'b00; dm[u] = 4'd2; dn[u] = 4'd2;
                a1[u] = 9'h000; ar[u] = 9'h100; start[u] = 1'b1;
            end
            if (kind == 1 && t == 2) start[u] = 1'b0;
            @(negedge clk);
        end
        start[u] = 1'b0;
        repeat (2) @(negedge clk);
        mon_on[u] = 1'b0;
        mism = 0;
        for (int k = 0; k < 512; k++) if (mem[u][k] !== expm[k]) mism++;
        chk("done_cycle", 32'(done_c[u]), bad ? 1 : 32'(mn + lat + 2));
        chk("err_pulse", 32'(err_seen[u]), bad ? 1 : 0);
        chk("busy_at_done", 32'(busy_at_done[u]), 0);
        chk("busy_after", 32'(busy[u]), 0);
        chk("reads", 32'(n_rd[u]), bad ? 0 : 32'(mn));
        chk("rd_order", 32'(rd_bad[u]), 0);
        chk("writes", 32'(n_wr[u]), bad ? 0 : 32'(mn));
        if (!bad) begin
            chk("first_wr", 32'(first_wr[u]), 32'(lat + 2));
            chk("last_wr", 32'(last_wr[u]), 32'(mn + lat + 1));
        end
        chk("mem_mismatch", 32'(mism), 0);
    endtask

    initial begin
        int none[$];
        int tv[$];
        int sv2[$];
        int u, m, n;
        logic [1:0] md;
        logic [8:0] ba, br;
        for (int g = 0; g < 2; g++) begin
            start[g] = 0; mode[g] = 0; dm[g] = 0; dn[g] = 0;
            a1[g] = 0; ar[g] = 0; sc[g] = 0; mon_on[g] = 0;
            for (int k = 0; k < 512; k++) mem[g][k] <= 8'h00;
        end
        tv  = '{1, 2, 3, 4, 5, 6};
        sv2 = '{50, -50, 10, 0};
        repeat (3) @(negedge clk);
        chk_idle_outputs(0, "reset0");
        chk_idle_outputs(1, "reset1");
        rst = 1'b0;
        @(negedge clk);

        run_op(0, 0, 2'b01, 2, 3, 9'h010, 9'h040, 8'h00, tv);
        chk("tr_res0", 32'(mem[0][9'h040]), 1);
        chk("tr_res1", 32'(mem[0][9'h041]), 4);
        chk("tr_res5", 32'(mem[0][9'h045]), 6);
        run_op(0, 0, 2'b10, 2, 2, 9'h080, 9'h0c0, 8'hfd, sv2);
        chk("sc_res0", 32'(mem[0][9'h0c0]), 32'h80);
        chk("sc_res1", 32'(mem[0][9'h0c1]), 32'h7f);
        chk("sc_res2", 32'(mem[0][9'h0c2]), 32'he2);
        run_op(1, 0, 2'b00, 4, 4, 9'h020, 9'h100, 8'h00, none);
        run_op(0, 0, 2'b00, 3, 0, 9'h020, 9'h100, 8'h00, none);
        run_op(1, 0, 2'b11, 2, 2, 9'h020, 9'h100, 8'h00, none);
        run_op(1, 0, 2'b00, 6, 2, 9'h020, 9'h100, 8'h00, none);
        run_op(0, 2, 2'b01, 3, 3, 9'h030, 9'h150, 8'h00, none);
        run_op(0, 0, 2'b01, 3, 3, 9'h030, 9'h150, 8'h00, none);
        run_op(0, 1, 2'b00, 1, 4, 9'h050, 9'h1fe, 8'h00, none);
        run_op(1, 0, 2'b10, 5, 5, 9'h1f0, 9'h0f8, 8'h7f, none);

        for (int r = 0; r < 40; r++) begin
            u  = r % 2;
            md = 2'($urandom_range(0, 2));
            m  = $urandom_range(1, 5);
            n  = $urandom_range(1, 5);
            if (r % 10 == 9) begin
                if (r % 20 == 9) md = 2'b11;
                else m = $urandom_range(6, 15);
            end
            ba = 9'($urandom_range(0, 511));
            br = 9'((int'(ba) + 256 + $urandom_range(0, 128)) % 512);
            run_op(u, 0, md, m, n, ba, br, 8'($urandom), none);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
